// File: rtl/add_pipe.sv
// Pipelined two's-complement adder/subtractor: one CHUNK-bit slice is resolved per stage and
// the inter-slice carry is registered. Valid/ready flow control lets empty stages fill under a stall.
module add_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             of
);
  localparam int CHUNK = WIDTH / STAGES;

  logic [WIDTH-1:0]  beff;
  logic              ceff;
  logic [STAGES-1:0] v_all;
  logic [STAGES-1:0] rdy;

  assign beff = sub ? ~b : b;
  assign ceff = sub ? ~cin : cin;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    localparam int CW = WIDTH - i * CHUNK;  // operand bits not yet consumed on entry to stage i

    logic [CW-1:0]          a_cur;
    logic [CW-1:0]          b_cur;
    logic                   c_cur;
    logic                   v_cur;
    logic [CHUNK:0]         sum;
    logic [(i+1)*CHUNK-1:0] r_next;
    logic [(i+1)*CHUNK-1:0] r_q;
    logic                   v_q;
    logic                   c_q;

    // A stage loads when it is empty or every stage downstream of it can advance.
    assign rdy[i]   = out_ready | ~(&v_all[STAGES-1:i]);
    assign v_all[i] = v_q;
    assign sum      = {1'b0, a_cur[CHUNK-1:0]} + {1'b0, b_cur[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, c_cur};

    if (i == 0) begin : g_first
      assign a_cur  = a;
      assign b_cur  = beff;
      assign c_cur  = ceff;
      assign v_cur  = in_valid;
      assign r_next = sum[CHUNK-1:0];
    end else begin : g_next
      assign a_cur  = g_stage[i-1].g_fwd.a_q;
      assign b_cur  = g_stage[i-1].g_fwd.b_q;
      assign c_cur  = g_stage[i-1].c_q;
      assign v_cur  = g_stage[i-1].v_q;
      assign r_next = {sum[CHUNK-1:0], g_stage[i-1].r_q};
    end

    // NOTE: non-blocking assignments make every stage sample its predecessor's pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        r_q <= '0;
      end else if (rdy[i]) begin
        v_q <= v_cur;
        if (v_cur) begin
          c_q <= sum[CHUNK];
          r_q <= r_next;
        end
      end
    end

    if (i < STAGES - 1) begin : g_fwd
      logic [CW-CHUNK-1:0] a_q;
      logic [CW-CHUNK-1:0] b_q;

      // NOTE: the unprocessed operand slices carry no reset; the stage valid bit alone qualifies them.
      always_ff @(posedge clk) begin
        if (rdy[i] && v_cur) begin
          a_q <= a_cur[CW-1:CHUNK];
          b_q <= b_cur[CW-1:CHUNK];
        end
      end
    end else begin : g_last
      logic of_q;

      // The top slice still holds the operand sign bits, so overflow is resolved here.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          of_q <= 1'b0;
        end else if (rdy[i] && v_cur) begin
          of_q <= (a_cur[CW-1] == b_cur[CW-1]) && (sum[CHUNK-1] != a_cur[CW-1]);
        end
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = g_stage[STAGES-1].v_q;
  assign s         = g_stage[STAGES-1].r_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign of        = g_stage[STAGES-1].g_last.of_q;

endmodule
